mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width; fixed 32 because wstrb is 4 bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req_valid/if_req_addr  input  1/ADDR_W  instruction-fetch read request.
REQ-006 SHALL have port if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port if_rsp_valid/if_rsp_data  output  1/DATA_W  fetch read data.
REQ-008 SHALL have port d_req_valid/d_req_we/d_req_addr/d_req_wdata/d_req_wstrb  input  1/1/ADDR_W/DATA_W/4  data load/store request.
REQ-009 SHALL have port d_req_ready  output  1  data request accepted this cycle.
REQ-010 SHALL have port d_rsp_valid/d_rsp_data  output  1/DATA_W  load data or store acknowledge.
REQ-011 SHALL have port mem_req_valid/mem_req_we/mem_req_addr/mem_req_wdata/mem_req_wstrb  output  1/1/ADDR_W/DATA_W/4  shared memory port request.
REQ-012 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-013 SHALL have port mem_rsp_valid/mem_rsp_data  input  1/DATA_W  memory response.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding.
REQ-015 IDLE: with any request valid, SHALL grant one requester, assert only its *_req_ready combinationally that cycle, capture its fields plus owner id, go to ISSUE.
REQ-016 Fixed-priority mode: data SHALL win over fetch when both valid in the same cycle.
REQ-017 ISSUE: mem_req_valid SHALL be 1 with captured fields held stable; on mem_req_ready go to WAIT.
REQ-018 Fetch requests SHALL drive mem_req_we=0 and mem_req_wstrb=0.
REQ-019 WAIT: on mem_rsp_valid SHALL register mem_rsp_data and go to RESP; stores also wait for mem_rsp_valid as acknowledge.
REQ-020 RESP: owner's *_rsp_valid SHALL be 1 for exactly one cycle with registered data, then IDLE; other requester's rsp_valid stays 0.
REQ-021 Minimum latency: accept at cycle T, mem_req_valid at T+1, rsp_valid at T+3 when mem_req_ready at T+1 and mem_rsp_valid at T+2.
REQ-022 *_req_ready SHALL be 0 in ISSUE, WAIT, RESP; requester may hold or drop valid while not accepted.
REQ-023 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-024 If mem_req_ready and mem_rsp_valid are both high in ISSUE, only mem_req_ready SHALL be acted upon that cycle.
REQ-025 *_rsp_data SHALL be 0 whenever the matching *_rsp_valid is 0.

Reset
REQ-026 resetn low SHALL immediately force IDLE; all ready/valid outputs 0, data/addr outputs 0, round-robin pointer to "data preferred".
REQ-027 Reset mid-transaction SHALL drop the outstanding transaction; a late mem_rsp_valid after reset SHALL be ignored (REQ-023).

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: SHALL use round-robin; on simultaneous requests the requester not granted last wins; pointer updates only on a grant.
REQ-029 MEM_ARB_RR_EN undefined: SHALL use fixed priority per REQ-016 and SHALL contain no pointer register.

Structure
REQ-030 Shared package SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP), the owner enum (OWN_IF, OWN_D) and the wstrb width constant 4.
REQ-031 Arbitration decision SHALL be a sub-module mem_arb_pick (inputs: two valids plus pointer; outputs: one-hot grant); FSM and datapath stay in mem_arb.

Verification
REQ-032 Fetch only, addr 0x80000000, memory returns 0x00000093 one cycle after accept -> if_rsp_valid one cycle at T+3 with data 0x00000093, d_rsp_valid stays 0.
REQ-033 Both valid same cycle (fixed priority) -> d_req_ready=1, if_req_ready=0; fetch granted only after d_rsp_valid.
REQ-034 MEM_ARB_RR_EN, both held valid for 4 transactions -> grants alternate D, IF, D, IF.
REQ-035 Store addr 0x80001000, wdata 0xDEADBEEF, wstrb 0xF, mem_req_ready low 3 cycles -> mem_req fields stable for 3 cycles; d_rsp_valid only after ack.
REQ-036 resetn pulsed low in WAIT, then mem_rsp_valid=1 -> all outputs 0, state IDLE, no rsp_valid pulse.
REQ-037 mem_rsp_valid=1 while IDLE with no requests -> no rsp_valid pulse; state remains IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for mem_arb: FSM states, request owner and write-strobe width.
// Round-robin arbitration is enabled with MEM_ARB_RR_EN; the default is data-over-fetch.
package mem_arb_pkg;

  localparam int WSTRB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_D) ? OWN_IF : OWN_D;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way arbiter: grant[1] = data, grant[0] = fetch; purely combinational.
// On a tie the requester named by ptr wins; a lone requester always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_valid,
  input  logic       d_valid,
  input  owner_t     ptr,
  output logic [1:0] grant
);

  logic d_win;
  logic if_win;

  always_comb begin
    d_win  = d_valid && (!if_valid || (ptr == OWN_D));
    if_win = if_valid && !d_win;
    grant  = {d_win, if_win};
  end

endmodule

// File: rtl/mem_arb.sv
// Fetch/data arbiter onto one memory port, one transaction in flight, rsp 3 cycles after accept at best.
// Requesters see ready only in IDLE; MEM_ARB_RR_EN selects round-robin instead of data-first.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               resetn,

  input  logic               if_req_valid,
  input  logic [ADDR_W-1:0]  if_req_addr,
  output logic               if_req_ready,
  output logic               if_rsp_valid,
  output logic [DATA_W-1:0]  if_rsp_data,

  input  logic               d_req_valid,
  input  logic               d_req_we,
  input  logic [ADDR_W-1:0]  d_req_addr,
  input  logic [DATA_W-1:0]  d_req_wdata,
  input  logic [WSTRB_W-1:0] d_req_wstrb,
  output logic               d_req_ready,
  output logic               d_rsp_valid,
  output logic [DATA_W-1:0]  d_rsp_data,

  output logic               mem_req_valid,
  output logic               mem_req_we,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic [DATA_W-1:0]  mem_req_wdata,
  output logic [WSTRB_W-1:0] mem_req_wstrb,
  input  logic               mem_req_ready,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rsp_data
);

  typedef struct packed {
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [WSTRB_W-1:0] wstrb;
  } req_t;

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  owner_t            ptr;
  req_t              req_q;
  logic [DATA_W-1:0] rsp_q;
  logic [1:0]        grant;
  logic              take;

  mem_arb_pick u_pick (
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .ptr      (ptr),
    .grant    (grant)
  );

`ifdef MEM_ARB_RR_EN
  // Prefer whichever side lost the most recent grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= OWN_D;
    end else if (take) begin
      ptr <= grant[1] ? OWN_IF : OWN_D;
    end
  end
`else
  assign ptr = OWN_D;
`endif

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          take      = resetn;
          state_nxt = ISSUE;
        end
      end
      // A response arriving alongside mem_req_ready is not ours yet.
      ISSUE:   if (mem_req_ready) state_nxt = WAIT;
      WAIT:    if (mem_rsp_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= OWN_IF;
      req_q <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        if (grant[1]) begin
          owner <= OWN_D;
          req_q <= '{we: d_req_we, addr: d_req_addr, wdata: d_req_wdata, wstrb: d_req_wstrb};
        end else begin
          owner <= OWN_IF;
          req_q <= '{we: 1'b0, addr: if_req_addr, wdata: '0, wstrb: '0};
        end
      end
      if ((state == WAIT) && mem_rsp_valid) begin
        rsp_q <= mem_rsp_data;
      end
    end
  end

  assign if_req_ready  = take & grant[0];
  assign d_req_ready   = take & grant[1];

  assign mem_req_valid = (state == ISSUE);
  assign mem_req_we    = mem_req_valid & req_q.we;
  assign mem_req_addr  = mem_req_valid ? req_q.addr  : '0;
  assign mem_req_wdata = mem_req_valid ? req_q.wdata : '0;
  assign mem_req_wstrb = mem_req_valid ? req_q.wstrb : '0;

  assign if_rsp_valid  = (state == RESP) && (owner == OWN_IF);
  assign d_rsp_valid   = (state == RESP) && (owner == OWN_D);
  assign if_rsp_data   = if_rsp_valid ? rsp_q : '0;
  assign d_rsp_data    = d_rsp_valid  ? rsp_q : '0;

  a_one_ready: assert property (@(posedge clk) disable iff (!resetn)
    !(if_req_ready && d_req_ready));

  a_one_rsp: assert property (@(posedge clk) disable iff (!resetn)
    !(if_rsp_valid && d_rsp_valid));

  a_req_hold: assert property (@(posedge clk) disable iff (!resetn)
    (mem_req_valid && !mem_req_ready) |=> (mem_req_valid && $stable(mem_req_addr) &&
      $stable(mem_req_wdata) && $stable(mem_req_wstrb) && $stable(mem_req_we)));

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus a randomized run against a transaction model.
// Expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OW = 4 + AW + DW + WSTRB_W + 1 + DW + 1 + DW;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               resetn;
  logic               if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0]      if_req_addr;
  logic [DW-1:0]      if_rsp_data;
  logic               d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
  logic [AW-1:0]      d_req_addr;
  logic [DW-1:0]      d_req_wdata, d_rsp_data;
  logic [WSTRB_W-1:0] d_req_wstrb;
  logic               mem_req_valid, mem_req_we, mem_req_ready, mem_rsp_valid;
  logic [AW-1:0]      mem_req_addr;
  logic [DW-1:0]      mem_req_wdata, mem_rsp_data;
  logic [WSTRB_W-1:0] mem_req_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  function automatic logic [OW-1:0] outs();
    return {if_req_ready, d_req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
            mem_req_wstrb, if_rsp_valid, if_rsp_data, d_rsp_valid, d_rsp_data};
  endfunction

  // Inputs change 2 time units after each rising edge; outputs are read 1 unit later.
  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    if_req_valid = 0; if_req_addr = '0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_wstrb = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    next_cyc();
    next_cyc();
    resetn = 1;
    next_cyc();
  endtask

  // Let the memory accept and answer until a response pulse appears; leaves the DUT idle.
  task automatic drain(output bit ok);
    ok = 0;
    if_req_valid = 0; d_req_valid = 0;
    for (int i = 0; i < 20; i++) begin
      mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = $urandom;
      #1;
      if (if_rsp_valid || d_rsp_valid) begin
        ok = 1;
        break;
      end
      next_cyc();
    end
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_reset();
    resetn = 0;
    if_req_valid = 1; if_req_addr = 32'h8000_0000;
    d_req_valid = 1; d_req_addr = 32'h1234_5678; d_req_we = 1; d_req_wdata = 32'hFFFF_FFFF; d_req_wstrb = 4'hF;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D;
    next_cyc(); next_cyc();
    #1;
    n_cmp++;
    if (outs() !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", outs());
    end
    n_cmp++;
    if ({if_req_ready, d_req_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", {if_req_ready, d_req_ready});
    end
    idle_inputs();
    resetn = 1;
    next_cyc();
  endtask

  task automatic test_fetch();
    if_req_valid = 1; if_req_addr = 32'h8000_0000;
    #1;
    n_cmp++;
    if ({if_req_ready, d_req_ready} !== 2'b10) begin
      n_err++; $display("FAIL fetch_accept: got %b want 10", {if_req_ready, d_req_ready});
    end
    next_cyc();
    if_req_valid = 0; mem_req_ready = 1;
    #1;
    n_cmp++;
    if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wstrb} !== {1'b1, 1'b0, 32'h8000_0000, 4'h0}) begin
      n_err++; $display("FAIL fetch_issue: got v=%b we=%b a=%h s=%h want 1 0 80000000 0",
                        mem_req_valid, mem_req_we, mem_req_addr, mem_req_wstrb);
    end
    next_cyc();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0093;
    #1;
    n_cmp++;
    if ({mem_req_valid, if_rsp_valid, d_rsp_valid} !== 3'b000) begin
      n_err++; $display("FAIL fetch_wait: got %b want 000", {mem_req_valid, if_rsp_valid, d_rsp_valid});
    end
    next_cyc();
    mem_rsp_valid = 0; mem_rsp_data = '0;
    #1;
    n_cmp++;
    if ({if_rsp_valid, if_rsp_data, d_rsp_valid} !== {1'b1, 32'h0000_0093, 1'b0}) begin
      n_err++; $display("FAIL fetch_rsp_t3: got v=%b d=%h dv=%b want 1 00000093 0",
                        if_rsp_valid, if_rsp_data, d_rsp_valid);
    end
    next_cyc();
    #1;
    n_cmp++;
    if ({if_rsp_valid, if_rsp_data} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL fetch_rsp_once: got v=%b d=%h want 0 0", if_rsp_valid, if_rsp_data);
    end
  endtask

  task automatic test_priority();
    bit if_early;
    bit ok;
    do_reset();
    if_early = 0;
    d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h1000_0040;
    if_req_valid = 1; if_req_addr = 32'h8000_0004;
    #1;
    n_cmp++;
    if ({if_req_ready, d_req_ready} !== 2'b01) begin
      n_err++; $display("FAIL prio_tie: got if/d ready %b want 01", {if_req_ready, d_req_ready});
    end
    next_cyc();
    d_req_valid = 0; mem_req_ready = 1;
    #1;
    if_early |= if_req_ready;
    n_cmp++;
    if (mem_req_addr !== 32'h1000_0040) begin
      n_err++; $display("FAIL prio_issue_addr: got %h want 10000040", mem_req_addr);
    end
    next_cyc();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_1111;
    #1;
    if_early |= if_req_ready;
    next_cyc();
    mem_rsp_valid = 0;
    #1;
    if_early |= if_req_ready;
    n_cmp++;
    if ({d_rsp_valid, d_rsp_data, if_rsp_valid} !== {1'b1, 32'h0000_1111, 1'b0}) begin
      n_err++; $display("FAIL prio_d_rsp: got v=%b d=%h iv=%b want 1 00001111 0", d_rsp_valid, d_rsp_data, if_rsp_valid);
    end
    n_cmp++;
    if (if_early !== 1'b0) begin
      n_err++; $display("FAIL prio_if_held: fetch ready seen %b before data response, want 0", if_early);
    end
    next_cyc();
    #1;
    n_cmp++;
    if ({if_req_ready, d_req_ready} !== 2'b10) begin
      n_err++; $display("FAIL prio_if_after: got if/d ready %b want 10", {if_req_ready, d_req_ready});
    end
    next_cyc();
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL prio_drain: response seen %b want 1", ok);
    end
  endtask

  task automatic test_alternate();
    owner_t got[$];
    owner_t exp_o;
    bit ok;
    do_reset();
    d_req_valid = 1; d_req_addr = 32'h2000_0000; if_req_valid = 1; if_req_addr = 32'h8000_0100;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h5555_AAAA;
    for (int i = 0; i < 40 && got.size() < 4; i++) begin
      #1;
      if (d_req_ready) got.push_back(OWN_D);
      else if (if_req_ready) got.push_back(OWN_IF);
      if (got.size() < 4) next_cyc();
    end
    n_cmp++;
    if (got.size() != 4) begin
      n_err++; $display("FAIL alt_count: got %0d grants want 4", got.size());
    end
    exp_o = OWN_D;
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_o) begin
        n_err++; $display("FAIL alt_grant%0d: got %s want %s", i, got[i].name(), exp_o.name());
      end
      if (RR) exp_o = other_owner(exp_o);
    end
    next_cyc();
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL alt_drain: response seen %b want 1", ok);
    end
  endtask

  task automatic test_store_stall();
    logic [1+1+AW+DW+WSTRB_W-1:0] exp_req;
    bit early;
    exp_req = {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF};
    early = 0;
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h8000_1000; d_req_wdata = 32'hDEAD_BEEF; d_req_wstrb = 4'hF;
    #1;
    n_cmp++;
    if (d_req_ready !== 1'b1) begin
      n_err++; $display("FAIL store_accept: got %b want 1", d_req_ready);
    end
    next_cyc();
    d_req_valid = 0; d_req_wdata = '0; d_req_addr = '0;
    for (int k = 0; k < 3; k++) begin
      mem_req_ready = 0; mem_rsp_valid = (k == 1); mem_rsp_data = 32'h0BAD_0BAD;
      #1;
      n_cmp++;
      if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb} !== exp_req) begin
        n_err++; $display("FAIL store_stall%0d: got %h want %h", k,
                          {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb}, exp_req);
      end
      next_cyc();
    end
    mem_req_ready = 1; mem_rsp_valid = 0;
    next_cyc();
    mem_req_ready = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      early |= d_rsp_valid | mem_req_valid;
      next_cyc();
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_err++; $display("FAIL store_no_early_ack: got %b want 0", early);
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'hACAC_ACAC;
    next_cyc();
    mem_rsp_valid = 0;
    #1;
    n_cmp++;
    if ({d_rsp_valid, d_rsp_data, if_rsp_valid} !== {1'b1, 32'hACAC_ACAC, 1'b0}) begin
      n_err++; $display("FAIL store_ack: got v=%b d=%h iv=%b want 1 acacacac 0", d_rsp_valid, d_rsp_data, if_rsp_valid);
    end
    next_cyc();
    #1;
    n_cmp++;
    if ({d_rsp_valid, d_rsp_data} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL store_ack_once: got v=%b d=%h want 0 0", d_rsp_valid, d_rsp_data);
    end
  endtask

  task automatic test_reset_in_wait();
    bit pulse;
    bit ok;
    pulse = 0;
    if_req_valid = 1; if_req_addr = 32'h8000_0200;
    next_cyc();
    if_req_valid = 0; mem_req_ready = 1;
    next_cyc();
    mem_req_ready = 0;
    #1;
    resetn = 0; if_req_valid = 1;
    #1;
    n_cmp++;
    if (outs() !== '0) begin
      n_err++; $display("FAIL rst_wait_outputs: got %h want 0", outs());
    end
    next_cyc();
    resetn = 1; if_req_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h7777_7777;
    for (int k = 0; k < 3; k++) begin
      #1;
      pulse |= if_rsp_valid | d_rsp_valid;
      next_cyc();
      mem_rsp_valid = 0;
    end
    n_cmp++;
    if (pulse !== 1'b0) begin
      n_err++; $display("FAIL rst_wait_late_rsp: rsp pulse %b want 0", pulse);
    end
    if_req_valid = 1;
    #1;
    n_cmp++;
    if (if_req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_wait_idle: ready %b want 1", if_req_ready);
    end
    next_cyc();
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL rst_wait_drain: response seen %b want 1", ok);
    end
  endtask

  task automatic test_idle_rsp();
    bit seen;
    bit ok;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      mem_rsp_valid = 1; mem_rsp_data = $urandom;
      #1;
      seen |= if_rsp_valid | d_rsp_valid | mem_req_valid;
      next_cyc();
    end
    mem_rsp_valid = 0;
    #1;
    seen |= if_rsp_valid | d_rsp_valid;
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL idle_rsp_ignored: activity %b want 0", seen);
    end
    d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h3000_0000;
    #1;
    n_cmp++;
    if (d_req_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_rsp_still_idle: ready %b want 1", d_req_ready);
    end
    next_cyc();
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL idle_rsp_drain: response seen %b want 1", ok);
    end
  endtask

  // Transaction model: one request at a time travels accept -> memory accept -> memory answer -> pulse.
  task automatic test_random();
    bit busy, issued, due, pref_d, g_d, g_i, mv, iv, dv;
    owner_t own;
    logic               c_we;
    logic [AW-1:0]      c_addr;
    logic [DW-1:0]      c_wdata, m_rsp;
    logic [WSTRB_W-1:0] c_wstrb;
    logic [OW-1:0]      exp_v;
    do_reset();
    busy = 0; issued = 0; due = 0; pref_d = 1; own = OWN_IF;
    c_we = 0; c_addr = '0; c_wdata = '0; c_wstrb = '0; m_rsp = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if_req_valid = ($urandom_range(0, 99) < 55);
      if_req_addr  = $urandom;
      d_req_valid  = ($urandom_range(0, 99) < 55);
      d_req_we     = ($urandom_range(0, 99) < 50);
      d_req_addr   = $urandom;
      d_req_wdata  = $urandom;
      d_req_wstrb  = 4'($urandom);
      mem_req_ready = ($urandom_range(0, 99) < 50);
      mem_rsp_valid = ($urandom_range(0, 99) < 40);
      mem_rsp_data  = $urandom;
      #1;
      g_d = !busy && d_req_valid && (!if_req_valid || pref_d);
      g_i = !busy && if_req_valid && !g_d;
      mv  = busy && !issued;
      iv  = due && (own == OWN_IF);
      dv  = due && (own == OWN_D);
      exp_v = {g_i, g_d, mv, mv & c_we, mv ? c_addr : '0, mv ? c_wdata : '0, mv ? c_wstrb : '0,
               iv, iv ? m_rsp : '0, dv, dv ? m_rsp : '0};
      n_cmp++;
      if (outs() !== exp_v) begin
        n_err++; $display("FAIL rand cyc %0d: got %h want %h", cyc, outs(), exp_v);
      end
      if (due) begin
        due = 0; busy = 0;
      end else if (busy && !issued) begin
        if (mem_req_ready) issued = 1;
      end else if (busy) begin
        if (mem_rsp_valid) begin
          m_rsp = mem_rsp_data; due = 1;
        end
      end else if (g_d || g_i) begin
        busy = 1; issued = 0;
        own     = g_d ? OWN_D : OWN_IF;
        c_we    = g_d ? d_req_we : 1'b0;
        c_addr  = g_d ? d_req_addr : if_req_addr;
        c_wdata = g_d ? d_req_wdata : '0;
        c_wstrb = g_d ? d_req_wstrb : '0;
        if (RR) pref_d = g_i;
      end
      next_cyc();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    test_reset();
    test_fetch();
    test_priority();
    test_alternate();
    test_store_stall();
    test_reset_in_wait();
    test_idle_rsp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
